// File: rtl/sine_seq_pkg.sv
// Shared constants and types for the sine tone sequencer.
// Holds the sweep note table, phase count and the FSM state encoding.
package sine_seq_pkg;

    // Sweep table, index 0 in the low slice: {40,36,32,30,27,24,21,20}.
    localparam logic [7:0][11:0] NOTE_TABLE = {
        12'd20, 12'd21, 12'd24, 12'd27,
        12'd30, 12'd32, 12'd36, 12'd40
    };

    localparam int PHASES = 36;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN
    } seq_state_e;

endpackage

// File: rtl/sine_seq_if.sv
// Control/status bundle between a host and the sine tone sequencer.
// master: start, stop, mode, fixed_n, step_dur out; n_out, n_update,
// pwm_en, busy, step_idx in. slave is the mirror image.
interface sine_seq_if #(
    parameter int DUR_W = 16
);
    logic             start;
    logic             stop;
    logic             mode;
    logic [11:0]      fixed_n;
    logic [DUR_W-1:0] step_dur;
    logic [11:0]      n_out;
    logic             n_update;
    logic             pwm_en;
    logic             busy;
    logic [2:0]       step_idx;

    modport master (
        output start, stop, mode, fixed_n, step_dur,
        input  n_out, n_update, pwm_en, busy, step_idx
    );

    modport slave (
        input  start, stop, mode, fixed_n, step_dur,
        output n_out, n_update, pwm_en, busy, step_idx
    );
endinterface

// File: rtl/sine_period_timer.sv
// Tick / interval / phase counters measuring one sine period.
// In: clk, rst, clear (holds all counters at 0), n (interval length).
// Out: pwm_tick (last clock of a PWM period), period_done (phase 35->0).
module sine_period_timer
    import sine_seq_pkg::*;
#(
    parameter int R = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [11:0] n,
    output logic        pwm_tick,
    output logic        period_done
);

    logic [R-1:0] tick_q, tick_d;
    logic [11:0]  ivl_q, ivl_d;
    logic [5:0]   ph_q, ph_d;
    logic         ivl_end;
    logic         ph_end;

    assign pwm_tick    = !clear && (tick_q == {R{1'b1}});
    assign ivl_end     = (ivl_q == n - 12'd1);
    assign ph_end      = (ph_q == 6'(PHASES - 1));
    assign period_done = pwm_tick && ivl_end && ph_end;

    always_comb begin
        tick_d = tick_q + R'(1);
        ivl_d  = ivl_q;
        ph_d   = ph_q;
        if (pwm_tick) begin
            if (ivl_end) begin
                ivl_d = '0;
                ph_d  = ph_end ? 6'd0 : ph_q + 6'd1;
            end else begin
                ivl_d = ivl_q + 12'd1;
            end
        end
        if (clear) begin
            tick_d = '0;
            ivl_d  = '0;
            ph_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
            ivl_q  <= '0;
            ph_q   <= '0;
        end else begin
            tick_q <= tick_d;
            ivl_q  <= ivl_d;
            ph_q   <= ph_d;
        end
    end

endmodule

// File: rtl/sine_tone_sequencer.sv
// Sequences N for the 36-phase sine PWM generator: fixed or table sweep,
// each N held for step_dur whole periods, changed only on period edges.
// Ports: clk, rst (sync, active high), bus (sine_seq_if slave).
module sine_tone_sequencer
    import sine_seq_pkg::*;
#(
    parameter int R      = 6,
    parameter int NSTEPS = 8,
    parameter int DUR_W  = 16
) (
    input  logic      clk,
    input  logic      rst,
    sine_seq_if.slave bus
);

    localparam logic [2:0] IDX_MASK = 3'(NSTEPS - 1);

    seq_state_e       state_q, state_d;
    logic [11:0]      n_q, n_d;
    logic             upd_q, upd_d;
    logic             en_q, en_d;
    logic             mode_q, mode_d;
    logic [2:0]       idx_q, idx_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [DUR_W-1:0] per_q, per_d;
    logic [11:0]      n_sel;
    logic             tmr_clr;
    logic             pwm_tick;
    logic             period_done;
    logic             step_end;

    // Counters sit at zero until the first RUN cycle after LOAD.
    assign tmr_clr  = (state_q == IDLE) || (state_q == LOAD);
    assign n_sel    = bus.mode ? NOTE_TABLE[idx_q] : bus.fixed_n;
    assign step_end = period_done && (per_q == dur_q - DUR_W'(1));

    sine_period_timer #(
        .R(R)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .clear       (tmr_clr),
        .n           (n_q),
        .pwm_tick    (pwm_tick),
        .period_done (period_done)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        upd_d   = 1'b0;
        en_d    = en_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        dur_d   = dur_q;
        per_d   = per_q;
        // period_done can only fire in RUN/DRAIN (timer cleared otherwise)
        if (period_done) begin
            per_d = step_end ? '0 : per_q + DUR_W'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                n_d     = (n_sel == 12'd0) ? 12'd1 : n_sel;
                dur_d   = (bus.step_dur == '0) ? DUR_W'(1) : bus.step_dur;
                mode_d  = bus.mode;
                upd_d   = 1'b1;
                en_d    = 1'b1;
                per_d   = '0;
                state_d = bus.stop ? DRAIN : RUN;
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = DRAIN;
                end else if (step_end && mode_q) begin
                    idx_d   = (idx_q + 3'd1) & IDX_MASK;
                    state_d = LOAD;
                end
            end
            DRAIN: begin
                if (period_done) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= NOTE_TABLE[0];
            upd_q   <= 1'b0;
            en_q    <= 1'b0;
            mode_q  <= 1'b0;
            idx_q   <= '0;
            dur_q   <= DUR_W'(1);
            per_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            upd_q   <= upd_d;
            en_q    <= en_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            dur_q   <= dur_d;
            per_q   <= per_d;
        end
    end

    assign bus.n_out    = n_q;
    assign bus.n_update = upd_q;
    assign bus.pwm_en   = en_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.step_idx = idx_q;

endmodule

// File: tb/tb_sine_tone_sequencer.sv
// Self-checking bench for sine_tone_sequencer (R=2, NSTEPS=8).
// Table vectors, random fixed-mode runs and hand-written corner sequences.
module tb_sine_tone_sequencer;

    localparam int R   = 2;
    localparam int TPP = 1 << R;

    typedef struct {
        logic [11:0] fn;
        logic [15:0] dur;
        int          j;
        int          exp_n;
        int          exp_h;
    } vec_t;

    logic clk;
    logic rst;
    int   cyc     = 0;
    int   en_cnt  = 0;
    int   upd_cnt = 0;
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   notes [8] = '{40, 36, 32, 30, 27, 24, 21, 20};

    sine_seq_if #(.DUR_W(16)) bus ();

    sine_tone_sequencer #(
        .R(R),
        .NSTEPS(8),
        .DUR_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.pwm_en) en_cnt++;
        if (bus.n_update) upd_cnt++;
    end

    task automatic check(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_start(bit m, logic [11:0] fn, logic [15:0] d,
                            bit with_stop);
        @(posedge clk); #1;
        bus.mode     = m;
        bus.fixed_n  = fn;
        bus.step_dur = d;
        bus.start    = 1'b1;
        bus.stop     = with_stop;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.stop = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(string nm, int max);
        int n = 0;
        while (bus.busy && n < max) begin
            @(negedge clk);
            n++;
        end
        check({nm, ".idle"}, int'(bus.busy), 0);
        #1;
    endtask

    task automatic wait_upd(string nm, int max, output int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.n_update && n < max);
        check({nm, ".upd_seen"}, int'(bus.n_update), 1);
        t = cyc;
    endtask

    // Fixed-mode run: stop lands in RUN cycle j; pwm_en must stay high
    // for exp_h cycles and n_update must pulse exactly once.
    task automatic run_fixed(string nm, logic [11:0] fn, logic [15:0] d,
                             int j, int exp_n, int exp_h);
        int e0;
        int u0;
        @(negedge clk); #1;
        e0 = en_cnt;
        u0 = upd_cnt;
        do_start(1'b0, fn, d, 1'b0);
        @(negedge clk);
        check({nm, ".load_busy"}, int'(bus.busy), 1);
        check({nm, ".load_upd"}, int'(bus.n_update), 0);
        @(negedge clk);
        check({nm, ".upd"}, int'(bus.n_update), 1);
        check({nm, ".n_out"}, int'(bus.n_out), exp_n);
        check({nm, ".pwm_en"}, int'(bus.pwm_en), 1);
        #1;
        repeat (j) @(posedge clk);
        #1;
        pulse_stop();
        wait_idle(nm, 10000);
        check({nm, ".en_len"}, en_cnt - e0, exp_h);
        check({nm, ".upd_cnt"}, upd_cnt - u0, 1);
    endtask

    vec_t vecs [5];

    initial begin
        int t0;
        int t1;
        int e0;
        int u0;

        vecs[0] = '{12'd2, 16'd1, 0,   2, 288};
        vecs[1] = '{12'd2, 16'd1, 300, 2, 576};
        vecs[2] = '{12'd0, 16'd1, 5,   1, 144};
        vecs[3] = '{12'd3, 16'd0, 431, 3, 864};
        vecs[4] = '{12'd1, 16'd3, 142, 1, 144};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.mode     = 1'b0;
        bus.fixed_n  = 12'd0;
        bus.step_dur = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.n_out", int'(bus.n_out), 40);
        check("rst.n_update", int'(bus.n_update), 0);
        check("rst.pwm_en", int'(bus.pwm_en), 0);
        check("rst.busy", int'(bus.busy), 0);
        check("rst.step_idx", int'(bus.step_idx), 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_fixed($sformatf("vec%0d", i), vecs[i].fn, vecs[i].dur,
                      vecs[i].j, vecs[i].exp_n, vecs[i].exp_h);
        end

        for (int i = 0; i < 6; i++) begin
            logic [11:0] fn;
            logic [15:0] d;
            int          n;
            int          p;
            int          j;
            fn = 12'($urandom_range(0, 4));
            d  = 16'($urandom_range(0, 3));
            n  = (fn == 0) ? 1 : int'(fn);
            p  = 36 * n * TPP;
            j  = $urandom_range(0, 2 * p + 10);
            run_fixed($sformatf("rnd%0d", i), fn, d, j, n,
                      p * ((j + 1) / p + 1));
        end

        // start+stop together in IDLE, then stop alone: both ignored
        @(negedge clk); #1;
        u0 = upd_cnt;
        do_start(1'b0, 12'd5, 16'd1, 1'b1);
        @(negedge clk);
        check("ss.busy", int'(bus.busy), 0);
        #1;
        pulse_stop();
        repeat (20) @(negedge clk);
        check("ss.busy_late", int'(bus.busy), 0);
        check("ss.upd_cnt", upd_cnt - u0, 0);

        // stop in LOAD, extra stop in DRAIN: exactly one period of output
        @(negedge clk); #1;
        e0 = en_cnt;
        u0 = upd_cnt;
        @(posedge clk); #1;
        bus.mode     = 1'b0;
        bus.fixed_n  = 12'd2;
        bus.step_dur = 16'd1;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        pulse_stop();
        repeat (10) @(posedge clk);
        #1;
        pulse_stop();
        wait_idle("sl", 10000);
        check("sl.en_len", en_cnt - e0, 288);
        check("sl.upd_cnt", upd_cnt - u0, 1);

        // Sweep, step_dur=2: first step length, start ignored, then reset
        do_start(1'b1, 12'd7, 16'd2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("sw2.upd0", int'(bus.n_update), 1);
        check("sw2.n0", int'(bus.n_out), 40);
        t0 = cyc;
        repeat (100) @(posedge clk);
        pulse_start();
        wait_upd("sw2", 12000, t1);
        check("sw2.step_len", t1 - t0, 2 * 36 * 40 * TPP + 1);
        check("sw2.n1", int'(bus.n_out), 36);
        check("sw2.idx1", int'(bus.step_idx), 1);
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_rst.n_out", int'(bus.n_out), 40);
        check("mid_rst.n_update", int'(bus.n_update), 0);
        check("mid_rst.pwm_en", int'(bus.pwm_en), 0);
        check("mid_rst.busy", int'(bus.busy), 0);
        check("mid_rst.step_idx", int'(bus.step_idx), 0);
        #1;
        rst = 1'b0;
        e0  = en_cnt;
        u0  = upd_cnt;
        repeat (300) @(negedge clk);
        check("post_rst.busy", int'(bus.busy), 0);
        check("post_rst.upd", upd_cnt - u0, 0);
        check("post_rst.en", en_cnt - e0, 0);

        // Full sweep with step_dur=0 (acts as 1), wrapping 7 -> 0
        do_start(1'b1, 12'd0, 16'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("wrap.upd0", int'(bus.n_update), 1);
        check("wrap.n0", int'(bus.n_out), 40);
        check("wrap.idx0", int'(bus.step_idx), 0);
        t0 = cyc;
        for (int s = 1; s <= 8; s++) begin
            wait_upd($sformatf("wrap%0d", s), 6000, t1);
            check($sformatf("wrap%0d.len", s), t1 - t0,
                  36 * notes[s-1] * TPP + 1);
            check($sformatf("wrap%0d.n", s), int'(bus.n_out), notes[s % 8]);
            check($sformatf("wrap%0d.idx", s), int'(bus.step_idx), s % 8);
            t0 = t1;
        end
        #1;
        pulse_stop();
        wait_idle("wrap", 10000);
        check("wrap.pwm_off", int'(bus.pwm_en), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
